// File: rtl/shift_arbiter_if.sv
// ---------------------------------------------------------------------------
// shift_arbiter_if
//   Bundles the two requester handshakes, the shared response bus, the
//   external shifter hookup and the status outputs of shift_arbiter.
//
//   Signals (direction as seen by the arbiter, i.e. the slave modport):
//     req<r>_valid/_data/_amount/_dir/_type  in   request r, r in {0,1}
//     req<r>_ready                           out  request r accepted
//     resp<r>_valid                          out  result for r available
//     resp<r>_ready                          in   requester r consumes result
//     resp_data                              out  shared result bus
//     sh_data_in/_shift_amount/
//       _shift_direction/_shift_type         out  to combinational shifter
//     sh_data_out                            in   shifter result
//     busy                                   out  FSM not in IDLE
//     grant_id                               out  owner of current operation
//
//   Modports: slave = the arbiter, master = requesters plus shifter.
// ---------------------------------------------------------------------------
interface shift_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic               req0_valid;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_data;
    logic [SHAMT_W-1:0] req0_amount;
    logic               req0_dir;
    logic               req0_type;

    logic               req1_valid;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_data;
    logic [SHAMT_W-1:0] req1_amount;
    logic               req1_dir;
    logic               req1_type;

    logic               resp0_valid;
    logic               resp0_ready;
    logic               resp1_valid;
    logic               resp1_ready;
    logic [DATA_W-1:0]  resp_data;

    logic [DATA_W-1:0]  sh_data_in;
    logic [SHAMT_W-1:0] sh_shift_amount;
    logic               sh_shift_direction;
    logic               sh_shift_type;
    logic [DATA_W-1:0]  sh_data_out;

    logic               busy;
    logic               grant_id;

    modport slave (
        input  req0_valid, req0_data, req0_amount, req0_dir, req0_type,
        input  req1_valid, req1_data, req1_amount, req1_dir, req1_type,
        input  resp0_ready, resp1_ready, sh_data_out,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        output sh_data_in, sh_shift_amount, sh_shift_direction, sh_shift_type,
        output busy, grant_id
    );

    modport master (
        output req0_valid, req0_data, req0_amount, req0_dir, req0_type,
        output req1_valid, req1_data, req1_amount, req1_dir, req1_type,
        output resp0_ready, resp1_ready, sh_data_out,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        input  sh_data_in, sh_shift_amount, sh_shift_direction, sh_shift_type,
        input  busy, grant_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//   Two-requester round-robin front end for an external combinational
//   shifter. One operation at a time: IDLE (arbitrate, accept) -> EXEC
//   (shifter sees latched operands, result captured) -> RESP (hold result
//   until the owner consumes it).
//
//   Ports:
//     clk    in  single clock, rising edge
//     rst_n  in  synchronous, active-low reset
//     bus    shift_arbiter_if.slave -- requests, responses, shifter, status
// ---------------------------------------------------------------------------
module shift_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]         state;
    logic [DATA_W-1:0]  op_data;
    logic [SHAMT_W-1:0] op_amount;
    logic               op_dir;
    logic               op_type;
    logic [DATA_W-1:0]  result_q;
    logic               grant_q;
    // Id of the requester served most recently; the other one wins a tie.
    logic               last_grant;

    logic               winner;
    logic               in_idle;
    logic               in_resp;
    logic               accept;
    logic               resp_fire;
    logic [DATA_W-1:0]  sel_data;
    logic [SHAMT_W-1:0] sel_amount;
    logic               sel_dir;
    logic               sel_type;

    // Arbitration and operand select.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a signal unassigned and no latch is inferred.
        winner     = 1'b0;
        sel_data   = bus.req0_data;
        sel_amount = bus.req0_amount;
        sel_dir    = bus.req0_dir;
        sel_type   = bus.req0_type;

        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant;
        end else if (bus.req1_valid) begin
            winner = 1'b1;
        end

        if (winner) begin
            sel_data   = bus.req1_data;
            sel_amount = bus.req1_amount;
            sel_dir    = bus.req1_dir;
            sel_type   = bus.req1_type;
        end
    end

    // NOTE: status and handshake outputs are qualified with rst_n so they
    // read 0 while reset is held, even before the synchronous reset has
    // taken effect on the state register.
    assign in_idle   = rst_n && (state == ST_IDLE);
    assign in_resp   = rst_n && (state == ST_RESP);
    assign accept    = in_idle && (bus.req0_valid || bus.req1_valid);
    assign resp_fire = in_resp && (grant_q ? bus.resp1_ready : bus.resp0_ready);

    assign bus.req0_ready  = in_idle && bus.req0_valid && !winner;
    assign bus.req1_ready  = in_idle && bus.req1_valid && winner;
    assign bus.resp0_valid = in_resp && !grant_q;
    assign bus.resp1_valid = in_resp && grant_q;
    assign bus.resp_data   = result_q;
    assign bus.busy        = rst_n && (state != ST_IDLE);
    assign bus.grant_id    = grant_q;

    // Shifter is fed only from the operand registers, never from the live
    // request inputs, so its inputs cannot move during EXEC.
    assign bus.sh_data_in         = rst_n ? op_data   : '0;
    assign bus.sh_shift_amount    = rst_n ? op_amount : '0;
    assign bus.sh_shift_direction = rst_n && op_dir;
    assign bus.sh_shift_type      = rst_n && op_type;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from values sampled at the same edge.
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_data    <= '0;
            op_amount  <= '0;
            op_dir     <= 1'b0;
            op_type    <= 1'b0;
            result_q   <= '0;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_data   <= sel_data;
                        op_amount <= sel_amount;
                        op_dir    <= sel_dir;
                        op_type   <= sel_type;
                        grant_q   <= winner;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= bus.sh_data_out;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_fire) begin
                        last_grant <= grant_q;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter
//   Directed bench for shift_arbiter. Provides a behavioural model of the
//   external combinational shifter and drives a linear sequence of requests
//   with hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_shift_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n;

    shift_arbiter_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External shifter model.
    always_comb begin
        bus.sh_data_out = bus.sh_data_in;
        if (!bus.sh_shift_direction) begin
            bus.sh_data_out = bus.sh_data_in << bus.sh_shift_amount;
        end else if (bus.sh_shift_type) begin
            bus.sh_data_out = 32'($signed(bus.sh_data_in) >>> bus.sh_shift_amount);
        end else begin
            bus.sh_data_out = bus.sh_data_in >> bus.sh_shift_amount;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic dir, input logic typ);
        if (r == 0) begin
            bus.req0_valid  = v;
            bus.req0_data   = d;
            bus.req0_amount = a;
            bus.req0_dir    = dir;
            bus.req0_type   = typ;
        end else begin
            bus.req1_valid  = v;
            bus.req1_data   = d;
            bus.req1_amount = a;
            bus.req1_dir    = dir;
            bus.req1_type   = typ;
        end
    endtask

    function automatic logic ready_of(input int r);
        return (r == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic resp_valid_of(input int r);
        return (r == 0) ? bus.resp0_valid : bus.resp1_valid;
    endfunction

    // One complete operation for requester r, with response ready held high.
    task automatic run_op(input int r, input logic [31:0] d, input logic [4:0] a,
                          input logic dir, input logic typ, input logic [31:0] exp,
                          input string tag);
        int k;
        drive(r, 1'b1, d, a, dir, typ);
        #1;
        k = 0;
        while (!ready_of(r) && k < 10) begin
            @(posedge clk); #2;
            k++;
        end
        check({tag, "_ready"}, ready_of(r), 1);
        @(posedge clk); #2;
        drive(r, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        k = 0;
        while (!resp_valid_of(r) && k < 10) begin
            @(posedge clk); #2;
            k++;
        end
        check({tag, "_resp_valid"}, resp_valid_of(r), 1);
        check({tag, "_data"}, bus.resp_data, exp);
        check({tag, "_grant"}, bus.grant_id, r);
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;

        // Reset state, with requests pending that must not be accepted.
        repeat (2) @(posedge clk);
        #2;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_resp0", bus.resp0_valid, 0);
        check("rst_resp1", bus.resp1_valid, 0);
        check("rst_sh_data", bus.sh_data_in, 32'h0);
        check("rst_grant", bus.grant_id, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Left shift by 4, with cycle-by-cycle latency.
        drive(0, 1'b1, 32'hA5A5A5A5, 5'd4, 1'b0, 1'b0);
        #1;
        check("a_ready0", bus.req0_ready, 1);
        check("a_ready1", bus.req1_ready, 0);
        check("a_busy_idle", bus.busy, 0);
        @(posedge clk); #2;
        drive(0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("a_busy_exec", bus.busy, 1);
        check("a_sh_data", bus.sh_data_in, 32'hA5A5A5A5);
        check("a_sh_amount", bus.sh_shift_amount, 4);
        check("a_resp_exec", bus.resp0_valid, 0);
        @(posedge clk); #2;
        check("a_resp_valid", bus.resp0_valid, 1);
        check("a_data", bus.resp_data, 32'h5A5A5A50);
        check("a_grant", bus.grant_id, 0);
        @(posedge clk); #2;
        check("a_done_busy", bus.busy, 0);
        check("a_done_resp", bus.resp0_valid, 0);

        // Right logical, right arithmetic, amount 0, left ignoring type.
        run_op(1, 32'hA5A5A5A5, 5'd8, 1'b1, 1'b0, 32'h00A5A5A5, "srl8");
        run_op(1, 32'hF0000000, 5'd4, 1'b1, 1'b1, 32'hFF000000, "sra4");
        run_op(0, 32'h80000001, 5'd0, 1'b1, 1'b1, 32'h80000001, "amt0");
        run_op(0, 32'h0000000F, 5'd4, 1'b0, 1'b1, 32'h000000F0, "sll_type");

        // Pointer reset: requester 0 was served last, reset must favour it again.
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        drive(0, 1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b0);
        drive(1, 1'b1, 32'h000000F0, 5'd4, 1'b1, 1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(bus.req0_ready || bus.req1_ready) && n < 10) begin
                @(posedge clk); #2;
                n++;
            end
            check("rr_ready0", bus.req0_ready, (k % 2 == 0));
            check("rr_ready1", bus.req1_ready, (k % 2 == 1));
            @(posedge clk); #2;
            check("rr_grant", bus.grant_id, k % 2);
            @(posedge clk); #2;
            check("rr_resp_valid", (k % 2 == 1) ? bus.resp1_valid : bus.resp0_valid, 1);
            check("rr_data", bus.resp_data, (k % 2 == 1) ? 32'h0000000F : 32'h00000F00);
            @(posedge clk); #2;
        end
        drive(0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

        // Response back-pressure on requester 0 while requester 1 waits.
        bus.resp0_ready = 1'b0;
        drive(0, 1'b1, 32'h00000001, 5'd31, 1'b0, 1'b0);
        drive(1, 1'b1, 32'h00000001, 5'd1, 1'b0, 1'b0);
        #1;
        check("bp_ready0", bus.req0_ready, 1);
        check("bp_ready1", bus.req1_ready, 0);
        @(posedge clk); #2;
        drive(0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("bp_resp_valid", bus.resp0_valid, 1);
        check("bp_data", bus.resp_data, 32'h80000000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            check("bp_hold_valid", bus.resp0_valid, 1);
            check("bp_hold_data", bus.resp_data, 32'h80000000);
            check("bp_hold_busy", bus.busy, 1);
            check("bp_hold_ready1", bus.req1_ready, 0);
        end
        bus.resp0_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_after_ready1", bus.req1_ready, 1);
        @(posedge clk); #2;
        drive(1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("bp_r1_valid", bus.resp1_valid, 1);
        check("bp_r1_data", bus.resp_data, 32'h00000002);
        @(posedge clk); #2;

        // Reset during EXEC abandons the operation.
        drive(0, 1'b1, 32'h12345678, 5'd4, 1'b0, 1'b0);
        #1;
        check("ab_ready0", bus.req0_ready, 1);
        @(posedge clk); #2;
        drive(0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        check("ab_busy_exec", bus.busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check("ab_busy", bus.busy, 0);
        check("ab_resp0", bus.resp0_valid, 0);
        check("ab_resp1", bus.resp1_valid, 0);
        check("ab_sh_data", bus.sh_data_in, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            check("ab_no_resp", bus.resp0_valid, 0);
            check("ab_idle", bus.busy, 0);
        end
        run_op(1, 32'h0000FFFF, 5'd16, 1'b0, 1'b0, 32'hFFFF0000, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
